// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory load/store port between the
// pipeline MEM stage (port 0) and the debug/program-loader port (port 1).
// The arbiter checks width and alignment, drives the memory bus from the
// granted port and registers a one-cycle response for that port. Port 1 can
// hold the bus with m1_lock. A lock that keeps port 0 waiting MAX_WAIT cycles
// is overridden.
//
// Optional feature: define DMEM_ARB_ROUND_ROBIN_EN to resolve ties in favour
// of the port not granted last. If it is undefined, port 0 wins every tie.

module dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_width,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_width,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_width,
    input  logic [31:0] mem_read_data
);

    localparam logic [2:0] MEM_BYTE   = 3'b000;
    localparam logic [2:0] MEM_HALF   = 3'b001;
    localparam logic [2:0] MEM_WORD   = 3'b010;
    localparam logic [2:0] MEM_BYTE_U = 3'b100;
    localparam logic [2:0] MEM_HALF_U = 3'b101;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    // A request is legal when the width is a known encoding and the address
    // is naturally aligned for that width.
    function automatic logic is_legal(input logic [2:0] width, input logic [1:0] addr_lo);
        logic ok;
        case (width)
            MEM_BYTE, MEM_BYTE_U: ok = 1'b1;
            MEM_HALF, MEM_HALF_U: ok = ~addr_lo[0];
            MEM_WORD:             ok = (addr_lo == 2'b00);
            default:              ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic        m0_legal, m1_legal;
    logic        m0_gnt_c, m1_gnt_c;

    logic        last_q, last_d;
    logic        lock_q, lock_d;
    logic [7:0]  wait_q, wait_d;

    logic        m0_rvalid_q, m0_rvalid_d;
    logic        m0_err_q, m0_err_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic        m1_rvalid_q, m1_rvalid_d;
    logic        m1_err_q, m1_err_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;

    assign m0_legal = is_legal(m0_width, m0_addr[1:0]);
    assign m1_legal = is_legal(m1_width, m1_addr[1:0]);

    // Grant selection: override, then lock, then single requester, then tie policy.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        m0_gnt_c = 1'b0;
        m1_gnt_c = 1'b0;
        if (!rst) begin
            if ((wait_q == WAIT_LIMIT) && m0_req) begin
                m0_gnt_c = 1'b1;
            end else if (lock_q && m1_req) begin
                m1_gnt_c = 1'b1;
            end else if (m0_req && m1_req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                if (last_q) begin
                    m0_gnt_c = 1'b1;
                end else begin
                    m1_gnt_c = 1'b1;
                end
`else
                m0_gnt_c = 1'b1;
`endif
            end else if (m0_req) begin
                m0_gnt_c = 1'b1;
            end else if (m1_req) begin
                m1_gnt_c = 1'b1;
            end
        end
    end

    assign m0_gnt = m0_gnt_c;
    assign m1_gnt = m1_gnt_c;

    // Memory bus: mux the granted port. Idle zeros when nothing is granted.
    // An illegal request drives neither strobe.
    always_comb begin
        mem_addr       = '0;
        mem_write_data = '0;
        mem_width      = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        if (m0_gnt_c) begin
            mem_addr       = m0_addr;
            mem_write_data = m0_wdata;
            mem_width      = m0_width;
            mem_read       = ~m0_we & m0_legal;
            mem_write      = m0_we & m0_legal;
        end else if (m1_gnt_c) begin
            mem_addr       = m1_addr;
            mem_write_data = m1_wdata;
            mem_width      = m1_width;
            mem_read       = ~m1_we & m1_legal;
            mem_write      = m1_we & m1_legal;
        end
    end

    // Next state for the arbitration registers and the per-port responses.
    always_comb begin
        lock_d = m1_gnt_c & m1_lock;

        if (m0_req && !m0_gnt_c) begin
            wait_d = (wait_q == WAIT_LIMIT) ? wait_q : wait_q + 8'd1;
        end else begin
            wait_d = '0;
        end

        last_d = last_q;
        if (m0_gnt_c) begin
            last_d = 1'b0;
        end else if (m1_gnt_c) begin
            last_d = 1'b1;
        end

        m0_rvalid_d = m0_gnt_c;
        m0_err_d    = m0_gnt_c & ~m0_legal;
        m0_rdata_d  = (m0_gnt_c && m0_legal && !m0_we) ? mem_read_data : '0;
        m1_rvalid_d = m1_gnt_c;
        m1_err_d    = m1_gnt_c & ~m1_legal;
        m1_rdata_d  = (m1_gnt_c && m1_legal && !m1_we) ? mem_read_data : '0;
    end

    // State and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            last_q      <= 1'b1;
            lock_q      <= 1'b0;
            wait_q      <= '0;
            m0_rvalid_q <= 1'b0;
            m0_err_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rvalid_q <= 1'b0;
            m1_err_q    <= 1'b0;
            m1_rdata_q  <= '0;
        end else begin
            last_q      <= last_d;
            lock_q      <= lock_d;
            wait_q      <= wait_d;
            m0_rvalid_q <= m0_rvalid_d;
            m0_err_q    <= m0_err_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rvalid_q <= m1_rvalid_d;
            m1_err_q    <= m1_err_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    // A response is held back while rst is high. A reset pulse in the cycle
    // after a grant therefore discards that response, and all response
    // outputs read zero for the whole reset interval.
    assign m0_rvalid = m0_rvalid_q & ~rst;
    assign m0_err    = m0_err_q & ~rst;
    assign m0_rdata  = rst ? '0 : m0_rdata_q;
    assign m1_rvalid = m1_rvalid_q & ~rst;
    assign m1_err    = m1_err_q & ~rst;
    assign m1_rdata  = rst ? '0 : m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model with its own shadow memory.

module tb_dmem_arbiter;

    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [2:0]  m0_width, m1_width;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_read, mem_write;
    logic [2:0]  mem_width;

    int total = 0;
    int bad   = 0;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_width(m0_width), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_width(m1_width), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_width(mem_width), .mem_read_data(mem_read_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Access size in bytes for a width code, 0 when the code is undefined.
    function automatic int acc_size(input logic [2:0] w);
        case (w)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit legal(input logic [2:0] w, input logic [31:0] a);
        int sz;
        sz = acc_size(w);
        return (sz != 0) && ((a % sz) == 0);
    endfunction

    // Memory-side formatting of load data (b0 is the byte at the address).
    function automatic logic [31:0] load_fmt(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3,
                                             input logic [2:0] w);
        case (w)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b100:  return {24'h0, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b101:  return {16'h0, b1, b0};
            3'b010:  return {b3, b2, b1, b0};
            default: return 32'h0;
        endcase
    endfunction

    // Data memory attached to the DUT bus (256 bytes, address wraps).
    logic [7:0] mem    [256];
    logic [7:0] shadow [256];
    logic [7:0] ra;
    assign ra = mem_addr[7:0];
    assign mem_read_data = load_fmt(mem[ra], mem[ra + 8'd1], mem[ra + 8'd2], mem[ra + 8'd3], mem_width);

    always @(negedge clk) begin
        if (mem_write) begin
            for (int i = 0; i < acc_size(mem_width); i++)
                mem[mem_addr[7:0] + 8'(i)] = mem_write_data[8*i +: 8];
        end
    end

    // Behavioural model state.
    int          m_wait = 0;
    bit          m_lock = 1'b0;
    int          m_last = 1;
    bit          r_v0 = 0, r_e0 = 0, r_v1 = 0, r_e1 = 0;
    logic [31:0] r_d0 = '0, r_d1 = '0;

    // Compare every cycle at the falling edge, then advance the model to the
    // state the coming rising edge will establish.
    always @(negedge clk) begin : model
        bit          g0, g1, l0, l1;
        logic [31:0] e_addr, e_wd;
        logic [2:0]  e_w;
        bit          e_rd, e_wr;
        logic [7:0]  a;
        if (model_on) begin
            g0 = 0; g1 = 0;
            l0 = legal(m0_width, m0_addr);
            l1 = legal(m1_width, m1_addr);
            if (!rst) begin
                if (m_wait == MAX_WAIT && m0_req)      g0 = 1;
                else if (m_lock && m1_req)             g1 = 1;
                else if (m0_req && m1_req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                    if (m_last == 0) g1 = 1; else g0 = 1;
`else
                    g0 = 1;
`endif
                end
                else if (m0_req)                       g0 = 1;
                else if (m1_req)                       g1 = 1;
            end
            e_addr = '0; e_wd = '0; e_w = '0; e_rd = 0; e_wr = 0;
            if (g0) begin
                e_addr = m0_addr; e_wd = m0_wdata; e_w = m0_width;
                e_rd = !m0_we && l0; e_wr = m0_we && l0;
            end else if (g1) begin
                e_addr = m1_addr; e_wd = m1_wdata; e_w = m1_width;
                e_rd = !m1_we && l1; e_wr = m1_we && l1;
            end
            check("m0_gnt", m0_gnt, g0);
            check("m1_gnt", m1_gnt, g1);
            check("mem_addr", mem_addr, e_addr);
            check("mem_write_data", mem_write_data, e_wd);
            check("mem_width", mem_width, e_w);
            check("mem_read", mem_read, e_rd);
            check("mem_write", mem_write, e_wr);
            check("m0_rvalid", m0_rvalid, rst ? 1'b0 : r_v0);
            check("m0_err", m0_err, rst ? 1'b0 : r_e0);
            check("m0_rdata", m0_rdata, rst ? 32'h0 : r_d0);
            check("m1_rvalid", m1_rvalid, rst ? 1'b0 : r_v1);
            check("m1_err", m1_err, rst ? 1'b0 : r_e1);
            check("m1_rdata", m1_rdata, rst ? 32'h0 : r_d1);

            if (rst) begin
                m_wait = 0; m_lock = 0; m_last = 1;
                r_v0 = 0; r_e0 = 0; r_d0 = '0;
                r_v1 = 0; r_e1 = 0; r_d1 = '0;
            end else begin
                a = e_addr[7:0];
                r_v0 = g0; r_e0 = g0 && !l0;
                r_v1 = g1; r_e1 = g1 && !l1;
                r_d0 = (g0 && e_rd) ? load_fmt(shadow[a], shadow[a + 8'd1], shadow[a + 8'd2], shadow[a + 8'd3], e_w) : '0;
                r_d1 = (g1 && e_rd) ? load_fmt(shadow[a], shadow[a + 8'd1], shadow[a + 8'd2], shadow[a + 8'd3], e_w) : '0;
                if (e_wr) begin
                    for (int i = 0; i < acc_size(e_w); i++)
                        shadow[a + 8'(i)] = e_wd[8*i +: 8];
                end
                m_lock = g1 && m1_lock;
                if (m0_req && !g0) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
                else               m_wait = 0;
                if (g0) m_last = 0;
                else if (g1) m_last = 1;
            end
        end
    end

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_width = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_width = '0; m1_lock = 0;
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    task automatic req0(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] w);
        m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wd; m0_width = w;
    endtask

    task automatic req1(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] w, input logic lk);
        m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_width = w; m1_lock = lk;
    endtask

    task automatic pulse_reset();
        rst = 1; idle();
        next();
        rst = 0;
    endtask

    task automatic rand_fields(output logic we, output logic [31:0] addr,
                               output logic [31:0] wd, output logic [2:0] w);
        logic [2:0] legal_w [5];
        logic [2:0] bad_w [3];
        legal_w = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        bad_w   = '{3'b011, 3'b110, 3'b111};
        we   = 1'($urandom_range(0, 1));
        addr = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
        wd   = $urandom;
        if ($urandom_range(0, 9) < 9) w = legal_w[$urandom_range(0, 4)];
        else                          w = bad_w[$urandom_range(0, 2)];
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int cnt1;
        bit got0;
        bit s0, s1;
        logic        we;
        logic [31:0] ad, wd;
        logic [2:0]  w;

        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'(i * 37 + 5);
            shadow[i] = 8'(i * 37 + 5);
        end
        rst = 1; idle();

        // Reset state.
        next();
        model_on = 1;
        @(negedge clk);
        check("rst_m0_gnt", m0_gnt, 0);
        check("rst_m1_rvalid", m1_rvalid, 0);
        check("rst_m0_rdata", m0_rdata, 0);
        check("rst_mem_bus", {mem_read, mem_write, mem_addr[29:0]}, 0);
        next();
        rst = 0;
        @(negedge clk);
        check("post_rst_m0_rvalid", m0_rvalid, 0);
        next();

        // Word store then load back.
        req0(1, 32'h10, 32'hDEADBEEF, 3'b010);
        @(negedge clk);
        check("st_gnt", m0_gnt, 1);
        check("st_mem_write", mem_write, 1);
        check("st_mem_addr", mem_addr, 32'h10);
        next();
        m0_req = 0;
        @(negedge clk);
        check("st_rvalid", m0_rvalid, 1);
        check("st_err", m0_err, 0);
        check("st_rdata", m0_rdata, 0);
        next();
        req0(0, 32'h10, 32'h0, 3'b010);
        @(negedge clk);
        check("ld_gnt", m0_gnt, 1);
        next();
        m0_req = 0;
        @(negedge clk);
        check("ld_rvalid", m0_rvalid, 1);
        check("ld_rdata", m0_rdata, 32'hDEADBEEF);
        next();

        // Tie policy from a fresh reset.
        pulse_reset();
        req0(0, 32'h10, 32'h0, 3'b010);
        req1(0, 32'h20, 32'h0, 3'b010, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            check("tie_m0_gnt", m0_gnt, (k % 2) == 0);
            check("tie_m1_gnt", m1_gnt, (k % 2) == 1);
`else
            check("tie_m0_gnt", m0_gnt, 1);
            check("tie_m1_gnt", m1_gnt, 0);
`endif
            next();
        end
        idle();

        // Misaligned half and undefined width.
        req0(0, 32'h11, 32'h0, 3'b001);
        @(negedge clk);
        check("mis_gnt", m0_gnt, 1);
        check("mis_mem_read", mem_read, 0);
        next();
        req0(0, 32'h20, 32'h0, 3'b011);
        @(negedge clk);
        check("mis_rvalid", m0_rvalid, 1);
        check("mis_err", m0_err, 1);
        check("mis_rdata", m0_rdata, 0);
        check("badw_mem_read", mem_read, 0);
        next();
        idle();
        @(negedge clk);
        check("badw_rvalid", m0_rvalid, 1);
        check("badw_err", m0_err, 1);
        check("badw_rdata", m0_rdata, 0);
        next();

        // Lock held against a waiting port 0 until the override.
        pulse_reset();
        req1(0, 32'h40, 32'h0, 3'b010, 1);
        @(negedge clk);
        check("lock_first_gnt", m1_gnt, 1);
        next();
        req0(0, 32'h44, 32'h0, 3'b010);
        cnt1 = 1; got0 = 0;
        for (int i = 0; i < 30 && !got0; i++) begin
            @(negedge clk);
            if (m1_gnt) cnt1++;
            else if (m0_gnt) got0 = 1;
            next();
        end
        check("lock_override_seen", got0, 1);
        check("lock_m1_grant_run", cnt1, 9);
        @(negedge clk);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        check("lock_cleared_m1_gnt", m1_gnt, 1);
`else
        check("lock_cleared_m0_gnt", m0_gnt, 1);
`endif
        next();
        idle();

        // Reset pulse in the response cycle of a locked port-1 load.
        pulse_reset();
        req1(0, 32'h40, 32'h0, 3'b010, 1);
        @(negedge clk);
        check("rstlock_gnt", m1_gnt, 1);
        next();
        rst = 1; idle();
        @(negedge clk);
        check("rstlock_rvalid", m1_rvalid, 0);
        next();
        rst = 0;
        req0(0, 32'h10, 32'h0, 3'b010);
        req1(0, 32'h40, 32'h0, 3'b010, 1);
        @(negedge clk);
        check("rstlock_tie_m0", m0_gnt, 1);
        check("rstlock_tie_m1", m1_gnt, 0);
        next();
        idle();

        // Port 0 gives up after three refused cycles.
        pulse_reset();
        req1(0, 32'h40, 32'h0, 3'b010, 1);
        next();
        req0(0, 32'h44, 32'h0, 3'b010);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("drop_wait_gnt", m0_gnt, 0);
            next();
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("drop_no_rvalid", m0_rvalid, 0);
            next();
        end

        // Randomized traffic; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            s0 = m0_gnt; s1 = m1_gnt;
            next();
            rst = ($urandom_range(0, 99) == 0);
            if (!m0_req || s0) begin
                if ($urandom_range(0, 1) == 1) begin
                    rand_fields(we, ad, wd, w);
                    req0(we, ad, wd, w);
                end else m0_req = 0;
            end else if ($urandom_range(0, 19) == 0) m0_req = 0;
            if (!m1_req || s1) begin
                if ($urandom_range(0, 2) == 0) begin
                    rand_fields(we, ad, wd, w);
                    req1(we, ad, wd, w, 1'($urandom_range(0, 1)));
                end else begin
                    m1_req = 0; m1_lock = 0;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                m1_req = 0; m1_lock = 0;
            end
        end
        rst = 0; idle();
        repeat (3) next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
